// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the divider sequencer: FSM state encoding,
// default operand width and RUN-phase watchdog limit, and a helper that
// sizes the watchdog counter.
package div_sequencer_pkg;

    localparam int unsigned DIV_WIDTH_DEF   = 10;
    localparam int unsigned DIV_TIMEOUT_DEF = 20;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ARM    = 3'd2,
        S_CHECK  = 3'd3,
        S_RUN    = 3'd4,
        S_RESULT = 3'd5
    } seq_state_t;

    // Counter width able to hold 0 .. timeout-1 (at least one bit).
    function automatic int unsigned wd_cnt_width(input int unsigned timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/div_watchdog.sv
// RUN-phase watchdog for the divider sequencer.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   i_clr     - clear the count to zero (wins over i_en)
//   i_en      - advance the count by one
//   o_tc_c    - terminal count: count equals TIMEOUT-1 (combinational decode)
module div_watchdog
    import div_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = DIV_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc_c
);

    localparam int unsigned CNT_W = wd_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count saturates at the terminal value so it can never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc_c) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tc_c = (r_cnt == TC_VAL);

endmodule

// File: rtl/div_sequencer.sv
// Control sequencer for an iterative divider. Accepts operand pairs into a
// one-deep pending buffer, moves them into the active register, walks the
// divider through reset/load, start, divide-by-zero check and run phases,
// and presents the result on a valid/ready output port.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   in_valid/in_ready/in_a/b  - operand pair input handshake
//   dv_rst, ld_a, ld_b        - divider reset and operand loads (LOAD)
//   loading_done, start       - divider operands valid / start pulse
//   dv_a, dv_b                - active operands to the divider
//   dv_q, dv_ov, dv_dvz, dv_co- divider quotient, flags and done
//   out_valid/out_ready       - result handshake
//   out_q, out_ov, out_dvz, out_to - quotient, overflow, div-by-zero, timeout
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH   = DIV_WIDTH_DEF,
    parameter int unsigned TIMEOUT = DIV_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             dv_rst,
    output logic             ld_a,
    output logic             ld_b,
    output logic             loading_done,
    output logic             start,
    output logic [WIDTH-1:0] dv_a,
    output logic [WIDTH-1:0] dv_b,
    input  logic [WIDTH-1:0] dv_q,
    input  logic             dv_ov,
    input  logic             dv_dvz,
    input  logic             dv_co,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic             out_ov,
    output logic             out_dvz,
    output logic             out_to
);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;

    logic             r_pend_full;
    logic [WIDTH-1:0] r_pend_a;
    logic [WIDTH-1:0] r_pend_b;
    logic [WIDTH-1:0] r_act_a;
    logic [WIDTH-1:0] r_act_b;

    logic             w_accept;
    logic             w_take;

    logic             w_wd_clr;
    logic             w_wd_en;
    logic             w_wd_tc_c;

    logic             w_res_ld;
    logic [WIDTH-1:0] w_res_q;
    logic             w_res_ov;
    logic             w_res_dvz;
    logic             w_res_to;

    logic             r_dv_rst;
    logic             r_ld;
    logic             r_start;
    logic             r_loading_done;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_q;
    logic             r_out_ov;
    logic             r_out_dvz;
    logic             r_out_to;

    assign w_accept = in_valid & ~r_pend_full;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, watchdog control and result capture.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_wd_clr    = 1'b0;
        w_wd_en     = 1'b0;
        w_res_ld    = 1'b0;
        w_res_q     = '0;
        w_res_ov    = 1'b0;
        w_res_dvz   = 1'b0;
        w_res_to    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_pend_full) begin
                    w_take      = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_ARM;
            end
            S_ARM: begin
                w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (dv_dvz) begin
                    w_res_ld    = 1'b1;
                    w_res_dvz   = 1'b1;
                    w_state_nxt = S_RESULT;
                end else begin
                    w_wd_clr    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_wd_en = 1'b1;
                // A done in the watchdog's terminal cycle still counts as done.
                if (dv_co) begin
                    w_res_ld    = 1'b1;
                    w_res_q     = dv_q;
                    w_res_ov    = dv_ov;
                    w_state_nxt = S_RESULT;
                end else if (w_wd_tc_c) begin
                    w_res_ld    = 1'b1;
                    w_res_to    = 1'b1;
                    w_state_nxt = S_RESULT;
                end
            end
            S_RESULT: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Pending and active operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_full <= 1'b0;
            r_pend_a    <= '0;
            r_pend_b    <= '0;
            r_act_a     <= '0;
            r_act_b     <= '0;
        end else begin
            r_pend_full <= (r_pend_full & ~w_take) | w_accept;
            if (w_accept) begin
                r_pend_a <= in_a;
                r_pend_b <= in_b;
            end
            if (w_take) begin
                r_act_a <= r_pend_a;
                r_act_b <= r_pend_b;
            end
        end
    end

    // Divider controls and out_valid, registered from the next state so they
    // line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dv_rst       <= 1'b1;
            r_ld           <= 1'b0;
            r_start        <= 1'b0;
            r_loading_done <= 1'b0;
            r_out_valid    <= 1'b0;
        end else begin
            r_dv_rst       <= (w_state_nxt == S_LOAD);
            r_ld           <= (w_state_nxt == S_LOAD);
            r_start        <= (w_state_nxt == S_ARM);
            r_loading_done <= (w_state_nxt == S_ARM) || (w_state_nxt == S_RUN);
            r_out_valid    <= (w_state_nxt == S_RESULT);
        end
    end

    // Result registers; held untouched while waiting for out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_q   <= '0;
            r_out_ov  <= 1'b0;
            r_out_dvz <= 1'b0;
            r_out_to  <= 1'b0;
        end else if (w_res_ld) begin
            r_out_q   <= w_res_q;
            r_out_ov  <= w_res_ov;
            r_out_dvz <= w_res_dvz;
            r_out_to  <= w_res_to;
        end
    end

    div_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_wd_clr),
        .i_en    (w_wd_en),
        .o_tc_c  (w_wd_tc_c)
    );

    assign in_ready     = ~r_pend_full;
    assign dv_rst       = r_dv_rst;
    assign ld_a         = r_ld;
    assign ld_b         = r_ld;
    assign start        = r_start;
    assign loading_done = r_loading_done;
    assign dv_a         = r_act_a;
    assign dv_b         = r_act_b;
    assign out_valid    = r_out_valid;
    assign out_q        = r_out_q;
    assign out_ov       = r_out_ov;
    assign out_dvz      = r_out_dvz;
    assign out_to       = r_out_to;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: a divider stub, a transaction-level
// result model with expected latencies, directed corner cases and a random run.
module tb_div_sequencer;

    localparam int W  = 10;
    localparam int TO = 20;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         dv_rst, ld_a, ld_b, loading_done, start;
    logic [W-1:0] dv_a, dv_b;
    logic [W-1:0] dv_q = '0;
    logic         dv_ov = 1'b0;
    logic         dv_dvz = 1'b0;
    logic         dv_co = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_q;
    logic         out_ov, out_dvz, out_to;

    always #5 clk = ~clk;

    div_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .dv_rst(dv_rst), .ld_a(ld_a), .ld_b(ld_b), .loading_done(loading_done),
        .start(start), .dv_a(dv_a), .dv_b(dv_b),
        .dv_q(dv_q), .dv_ov(dv_ov), .dv_dvz(dv_dvz), .dv_co(dv_co),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_ov(out_ov), .out_dvz(out_dvz), .out_to(out_to)
    );

    // d = cycles after start at which the stub raises dv_co (0 = never).
    typedef struct { logic [W-1:0] a; logic [W-1:0] b; int d; bit ov; int acc; } job_t;
    typedef struct { logic [W-1:0] q; logic ov; logic dvz; logic to; int lat; int acc; } res_t;

    job_t pend_q[$];
    res_t res_q[$];

    int checks = 0;
    int errors = 0;

    int   cyc = 0;
    int   n_acc = 0;
    int   n_res = 0;
    int   off_d = 0;
    bit   off_ov = 0;
    int   rdy_mode = 0;
    job_t cur;
    bit   have_cur = 0;
    bit   busy = 0;
    int   start_cyc = 0;
    bit   post_rst = 0;
    bit   prev_ld = 0;
    bit   held = 0;
    int   ldd_cnt = 0;
    logic [W-1:0] h_q;
    logic h_ov, h_dvz, h_to;
    logic [W-1:0] last_q;
    logic last_ov, last_dvz, last_to;
    int   last_start_lat, last_acc_lat, last_ldd;
    int   base_res, base_acc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected result and start-to-out_valid latency of one pair.
    function automatic res_t model(input job_t j);
        res_t r;
        r.acc = j.acc;
        if (j.b == '0) begin
            r.q = '0; r.ov = 1'b0; r.dvz = 1'b1; r.to = 1'b0; r.lat = 2;
        end else if (j.d == 0 || j.d > TO + 1) begin
            r.q = '0; r.ov = 1'b0; r.dvz = 1'b0; r.to = 1'b1; r.lat = TO + 2;
        end else begin
            r.q = j.a / j.b; r.ov = j.ov; r.dvz = 1'b0; r.to = 1'b0; r.lat = j.d + 1;
        end
        return r;
    endfunction

    // Monitor, divider stub and scoreboard; runs mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            pend_q.delete();
            res_q.delete();
            have_cur = 0; busy = 0; held = 0; prev_ld = 0; post_rst = 1;
            dv_co = 1'b0; dv_dvz = 1'b0; dv_q = '0; dv_ov = 1'b0;
        end else begin
            if (post_rst) begin
                chk("rst_in_ready", 32'(in_ready), 1);
                chk("rst_out_valid", 32'(out_valid), 0);
                chk("rst_dv_rst", 32'(dv_rst), 1);
                chk("rst_ld", 32'({ld_a, ld_b}), 0);
                chk("rst_start", 32'(start), 0);
                chk("rst_loading_done", 32'(loading_done), 0);
                chk("rst_dv_ab", 32'({dv_a, dv_b}), 0);
                chk("rst_out_fields", 32'({out_q, out_ov, out_dvz, out_to}), 0);
                post_rst = 0;
            end else begin
                chk("ld_b_with_ld_a", 32'(ld_b), 32'(ld_a));
                chk("dv_rst_with_ld", 32'(dv_rst), 32'(ld_a));
                chk("start_after_load", 32'(start), 32'(prev_ld));
            end

            if (ld_a) begin
                chk("load_has_job", 32'(pend_q.size() > 0), 1);
                if (pend_q.size() > 0) begin
                    cur = pend_q.pop_front();
                    have_cur = 1;
                    chk("load_dv_a", 32'(dv_a), 32'(cur.a));
                    chk("load_dv_b", 32'(dv_b), 32'(cur.b));
                end
                busy = 0;
                ldd_cnt = 0;
            end
            if (loading_done) ldd_cnt++;
            if (start) begin
                chk("start_loading_done", 32'(loading_done), 1);
                busy = have_cur;
                start_cyc = cyc;
            end

            dv_dvz = have_cur && (cur.b == '0);
            dv_co  = busy && (cur.b != '0) && (cur.d != 0) && (cyc - start_cyc == cur.d);
            if (dv_co) begin
                dv_q  = cur.a / cur.b;
                dv_ov = cur.ov;
                busy  = 0;
            end else begin
                dv_q  = W'($urandom);
                dv_ov = 1'($urandom);
            end

            if (held && !out_valid) chk("valid_held", 32'(out_valid), 1);
            if (out_valid) begin
                if (!held) begin
                    chk("result_expected", 32'(res_q.size() > 0), 1);
                    if (res_q.size() > 0) begin
                        chk("res_q", 32'(out_q), 32'(res_q[0].q));
                        chk("res_ov", 32'(out_ov), 32'(res_q[0].ov));
                        chk("res_dvz", 32'(out_dvz), 32'(res_q[0].dvz));
                        chk("res_to", 32'(out_to), 32'(res_q[0].to));
                        chk("res_latency", 32'(cyc - start_cyc), 32'(res_q[0].lat));
                        last_acc_lat = cyc - res_q[0].acc - 1;
                    end
                    last_q = out_q; last_ov = out_ov; last_dvz = out_dvz; last_to = out_to;
                    last_start_lat = cyc - start_cyc;
                    last_ldd = ldd_cnt;
                end else begin
                    chk("hold_fields", 32'({out_q, out_ov, out_dvz, out_to}),
                        32'({h_q, h_ov, h_dvz, h_to}));
                end
                h_q = out_q; h_ov = out_ov; h_dvz = out_dvz; h_to = out_to;
                if (out_ready) begin
                    if (res_q.size() > 0) void'(res_q.pop_front());
                    n_res++;
                    held = 0;
                end else begin
                    held = 1;
                end
            end else begin
                held = 0;
            end

            if (in_valid && in_ready) begin
                job_t j;
                j.a = in_a; j.b = in_b; j.d = off_d; j.ov = off_ov; j.acc = cyc;
                pend_q.push_back(j);
                res_q.push_back(model(j));
                n_acc++;
            end
            prev_ld = ld_a;
        end
    end

    // Result-side backpressure: 0 always ready, 1 random, 2 stalled.
    always @(posedge clk) begin
        #1;
        out_ready = (rdy_mode == 0) ? 1'b1 :
                    (rdy_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b, input int d, input bit ov);
        int  waited = 0;
        logic got;
        in_valid = 1'b1; in_a = a; in_b = b; off_d = d; off_ov = ov;
        @(negedge clk);
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        got = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("offer_accepted", 32'(got), 1);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (n_res < target && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("results_drained", 32'(n_res), 32'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [W-1:0] ra, rb;
        int rd;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        rdy_mode = 0;

        // 12 / 3 with done 14 cycles after start.
        base_res = n_res;
        offer(10'd12, 10'd3, 14, 1'b0);
        wait_done(base_res + 1);
        chk("t1_q", 32'(last_q), 4);
        chk("t1_flags", 32'({last_ov, last_dvz, last_to}), 0);
        chk("t1_start_lat", 32'(last_start_lat), 15);

        // Divide by zero: result four edges after acceptance, RUN skipped.
        base_res = n_res;
        offer(10'd37, 10'd0, 0, 1'b0);
        wait_done(base_res + 1);
        chk("t2_q", 32'(last_q), 0);
        chk("t2_dvz", 32'(last_dvz), 1);
        chk("t2_to", 32'(last_to), 0);
        chk("t2_acc_lat", 32'(last_acc_lat), 4);
        chk("t2_ldd_cycles", 32'(last_ldd), 1);

        // Divider never finishes: timeout after 20 RUN cycles.
        base_res = n_res;
        offer(10'd100, 10'd7, 0, 1'b0);
        wait_done(base_res + 1);
        chk("t3_to", 32'(last_to), 1);
        chk("t3_q", 32'(last_q), 0);
        chk("t3_ldd_cycles", 32'(last_ldd), 21);
        chk("t3_start_lat", 32'(last_start_lat), 22);

        // Done coincides with watchdog terminal: done wins.
        base_res = n_res;
        offer(10'd500, 10'd9, 21, 1'b1);
        wait_done(base_res + 1);
        chk("t4_to", 32'(last_to), 0);
        chk("t4_q", 32'(last_q), 55);
        chk("t4_ov", 32'(last_ov), 1);
        chk("t4_ldd_cycles", 32'(last_ldd), 21);

        // Three pairs back-to-back against a stalled output.
        rdy_mode = 2;
        base_res = n_res;
        base_acc = n_acc;
        offer(10'd50, 10'd5, 6, 1'b0);
        offer(10'd99, 10'd0, 0, 1'b0);
        chk("t5_ready_low", 32'(in_ready), 0);
        fork
            begin
                repeat (30) @(posedge clk);
                chk("t5_two_accepted", 32'(n_acc - base_acc), 2);
                chk("t5_none_out", 32'(n_res - base_res), 0);
                rdy_mode = 0;
            end
        join_none
        offer(10'd1000, 10'd3, 8, 1'b1);
        wait_done(base_res + 3);
        chk("t5_last_q", 32'(last_q), 333);

        // Reset while RUN with the pending register full.
        rdy_mode = 0;
        base_res = n_res;
        offer(10'd200, 10'd4, 0, 1'b0);
        offer(10'd300, 10'd5, 5, 1'b0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("t6_in_run", 32'(loading_done), 1);
        chk("t6_pend_full", 32'(in_ready), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_in_ready", 32'(in_ready), 1);
        chk("t6_out_valid", 32'(out_valid), 0);
        repeat (60) @(posedge clk);
        #1;
        chk("t6_no_stale", 32'(n_res - base_res), 0);

        // Random traffic with random backpressure.
        rdy_mode = 1;
        base_res = n_res;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            ra = W'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 40));
            rd = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(2, 24));
            offer(ra, rb, rd, 1'($urandom));
        end
        wait_done(base_res + 60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
